// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  localparam int REGW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/div_interlock.sv
// Multi-cycle divider interlock: holds the pipeline while the iterative divider runs.
//  state | meaning
//  IDLE  | no divide in flight; a start in E stalls combinationally and launches BUSY
//  BUSY  | divider iterating; cnt counts down to 0, pipeline held
//  DONE  | quotient valid this cycle, stalls released, new starts ignored
module div_interlock
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_start,
  input  logic exc,
  output logic divstall,
  output logic div_done,
  output logic div_cancel
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  div_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cancel_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_cancel <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      div_cancel <= cancel_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cancel_n = 1'b0;
    case (state)
      IDLE: begin
        if (div_start && !exc) begin
          state_n = BUSY;
          cnt_n   = CW'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        if (exc) begin
          state_n  = IDLE;
          cnt_n    = '0;
          cancel_n = 1'b1;
        end else if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DONE: begin
        state_n  = IDLE;
        cancel_n = exc;
      end
      default: state_n = IDLE;
    endcase
  end

  // An exception in DONE kills the result, so done is suppressed that cycle.
  assign divstall = ((state == IDLE) && div_start) || (state == BUSY);
  assign div_done = (state == DONE) && !exc;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward generation for a 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall_cycles counter output.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int REGW       = REGW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            pc_redirectD,
  input  logic            div_startE,
  input  logic            excM,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic            div_busy,
  output logic            div_done,
  output logic            div_cancel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  // r0 is hardwired zero, so it never creates a dependency.
  function automatic logic hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic lwstall, branchstall, divstall;

  div_interlock #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_startE),
    .exc        (excM),
    .divstall   (divstall),
    .div_done   (div_done),
    .div_cancel (div_cancel)
  );

  always_comb begin
    forwardAE = FWD_RF;
    if (regwriteM && hit(rsE, writeregM))      forwardAE = FWD_M;
    else if (regwriteW && hit(rsE, writeregW)) forwardAE = FWD_W;

    forwardBE = FWD_RF;
    if (regwriteM && hit(rtE, writeregM))      forwardBE = FWD_M;
    else if (regwriteW && hit(rtE, writeregW)) forwardBE = FWD_W;
  end

  assign forwardAD = regwriteM && hit(rsD, writeregM);
  assign forwardBD = regwriteM && hit(rtD, writeregM);

  assign lwstall     = memtoregE && regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE));
  assign branchstall = branchD &&
                       ((regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
                        (memtoregM && (hit(rsD, writeregM) || hit(rtD, writeregM))));

  // Exception overrides every stall; a divide stall suppresses the bubble flush.
  assign stallF   = (lwstall || branchstall || divstall) && !excM;
  assign stallD   = stallF;
  assign stallE   = divstall && !excM;
  assign flushE   = excM || ((lwstall || branchstall) && !divstall);
  assign flushD   = excM || (pc_redirectD && !stallD);
  assign flushM   = excM;
  assign div_busy = divstall;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   stall_cycles <= '0;
    else if (stallF && (stall_cycles != '1))    stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
